// File: rtl/mfp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mfp_pkg
//  Description : Shared constants, FSM state encoding and the priority helper
//                for the MFP interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mfp_pkg;

    localparam int MFP_NCH  = 16;
    localparam int VR_S_BIT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VEC   = 2'd1,
        NOACK = 2'd2
    } mfp_state_t;

    // Returns {valid, index of highest set bit}; bit 15 has the highest priority.
    function automatic logic [4:0] prio16(input logic [15:0] v);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) r = {1'b1, i[3:0]};
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mfp_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mfp_irq_ctrl_if
//  Description : Bus between the CPU/pending-register side and the MFP
//                interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mfp_irq_ctrl_if;
    import mfp_pkg::*;

    logic [MFP_NCH-1:0] ipr;
    logic [MFP_NCH-1:0] imr;
    logic [7:0]         vr;
    logic               isr_wr;
    logic [MFP_NCH-1:0] isr_wdata;
    logic               iack;
    logic               irq_n;
    logic [7:0]         vec;
    logic               vec_valid;
    logic [MFP_NCH-1:0] ipr_clr;
    logic [MFP_NCH-1:0] isr;

    // CPU / register-file side
    modport master (
        output ipr, imr, vr, isr_wr, isr_wdata, iack,
        input  irq_n, vec, vec_valid, ipr_clr, isr
    );

    // Interrupt controller side
    modport slave (
        input  ipr, imr, vr, isr_wr, isr_wdata, iack,
        output irq_n, vec, vec_valid, ipr_clr, isr
    );

endinterface
`default_nettype wire

// File: rtl/mfp_prio16.sv
`default_nettype none
// ============================================================================
//  Module      : mfp_prio16
//  Description : 16-to-4 highest-bit priority encoder with valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mfp_prio16
    import mfp_pkg::*;
(
    input  wire logic [15:0] i_req,
    output logic             o_valid,
    output logic [3:0]       o_idx
);

    logic [4:0] w_res;

    // Highest set bit wins
    always_comb begin
        w_res   = prio16(i_req);
        o_valid = w_res[4];
        o_idx   = w_res[3:0];
    end

endmodule
`default_nettype wire

// File: rtl/mfp_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mfp_irq_ctrl
//  Description : MFP interrupt prioritisation, in-service tracking, IRQ
//                generation and IACK vector response.
//  Revision    : 1.0 - initial release
// ============================================================================
module mfp_irq_ctrl
    import mfp_pkg::*;
#(
    parameter int NCH = MFP_NCH   // only 16 is supported
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    mfp_irq_ctrl_if.slave  bus
);

    localparam logic [NCH-1:0] c_ONE = {{(NCH-1){1'b0}}, 1'b1};

    mfp_state_t       r_state;
    mfp_state_t       w_state_nxt;
    logic             r_iack_d;
    logic             r_irq_n;
    logic             w_irq_n_nxt;
    logic [7:0]       r_vec;
    logic [7:0]       w_vec_nxt;
    logic             r_vec_valid;
    logic             w_vec_valid_nxt;
    logic [NCH-1:0]   r_ipr_clr;
    logic [NCH-1:0]   w_ipr_clr_nxt;
    logic [NCH-1:0]   r_isr;
    logic [NCH-1:0]   w_isr_nxt;
    logic [NCH-1:0]   w_isr_base;
    logic [NCH-1:0]   w_set_onehot;
    logic [NCH-1:0]   w_act;
    logic [NCH-1:0]   w_hp_onehot;
    logic             w_act_valid;
    logic [3:0]       w_hp_act;
    logic             w_isr_valid;
    logic [3:0]       w_hp_isr;
    logic             w_req;
    logic             w_iack_rise;
    logic             w_s_mode;

    assign w_act       = bus.ipr & bus.imr;
    assign w_s_mode    = bus.vr[VR_S_BIT];
    assign w_iack_rise = bus.iack & ~r_iack_d;
    assign w_hp_onehot = c_ONE << w_hp_act;

    mfp_prio16 u_prio_act (
        .i_req   (w_act),
        .o_valid (w_act_valid),
        .o_idx   (w_hp_act)
    );

    mfp_prio16 u_prio_isr (
        .i_req   (r_isr),
        .o_valid (w_isr_valid),
        .o_idx   (w_hp_isr)
    );

    // A request exists only if it outranks everything currently in service
    assign w_req = w_act_valid && (!w_isr_valid || (w_hp_act > w_hp_isr));

    // Next-state and registered-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_irq_n_nxt     = 1'b1;
        w_vec_nxt       = r_vec;
        w_vec_valid_nxt = r_vec_valid;
        w_ipr_clr_nxt   = '0;
        w_set_onehot    = '0;
        case (r_state)
            IDLE: begin
                w_irq_n_nxt = ~w_req;
                if (w_iack_rise) begin
                    if (w_req) begin
                        // Channel is frozen into vec here and held through VEC
                        w_state_nxt     = VEC;
                        w_vec_nxt       = {bus.vr[7:4], w_hp_act};
                        w_vec_valid_nxt = 1'b1;
                        w_ipr_clr_nxt   = w_hp_onehot;
                        if (w_s_mode) w_set_onehot = w_hp_onehot;
                    end else begin
                        w_state_nxt = NOACK;
                    end
                end
            end
            VEC: begin
                if (!bus.iack) begin
                    w_vec_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            NOACK: begin
                if (!bus.iack) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt     = IDLE;
                w_vec_valid_nxt = 1'b0;
            end
        endcase
    end

    // ISR update: CPU clear first, then acknowledge set so set wins;
    // automatic end-of-interrupt mode keeps the register empty
    always_comb begin
        w_isr_base = bus.isr_wr ? (r_isr & bus.isr_wdata) : r_isr;
        w_isr_nxt  = w_s_mode ? (w_isr_base | w_set_onehot) : '0;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_iack_d    <= 1'b0;
            r_irq_n     <= 1'b1;
            r_vec       <= 8'h00;
            r_vec_valid <= 1'b0;
            r_ipr_clr   <= '0;
            r_isr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_iack_d    <= bus.iack;
            r_irq_n     <= w_irq_n_nxt;
            r_vec       <= w_vec_nxt;
            r_vec_valid <= w_vec_valid_nxt;
            r_ipr_clr   <= w_ipr_clr_nxt;
            r_isr       <= w_isr_nxt;
        end
    end

    assign bus.irq_n     = r_irq_n;
    assign bus.vec       = r_vec;
    assign bus.vec_valid = r_vec_valid;
    assign bus.ipr_clr   = r_ipr_clr;
    assign bus.isr       = r_isr;

endmodule
`default_nettype wire

// File: tb/tb_mfp_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mfp_irq_ctrl
//  Description : Directed self-checking bench for mfp_irq_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mfp_irq_ctrl;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    mfp_irq_ctrl_if bus ();

    mfp_irq_ctrl #(.NCH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.ipr       = '0;
        bus.imr       = '0;
        bus.vr        = '0;
        bus.isr_wr    = 1'b0;
        bus.isr_wdata = '0;
        bus.iack      = 1'b0;
        step(); step();
        tests++; if (bus.irq_n !== 1'b1) begin fails++; $display("FAIL rst_irq_n: got %b want 1", bus.irq_n); end
        tests++; if (bus.vec !== 8'h00) begin fails++; $display("FAIL rst_vec: got %h want 00", bus.vec); end
        tests++; if (bus.vec_valid !== 1'b0) begin fails++; $display("FAIL rst_vec_valid: got %b want 0", bus.vec_valid); end
        tests++; if (bus.ipr_clr !== 16'h0000) begin fails++; $display("FAIL rst_ipr_clr: got %h want 0000", bus.ipr_clr); end
        tests++; if (bus.isr !== 16'h0000) begin fails++; $display("FAIL rst_isr: got %h want 0000", bus.isr); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        bus.ipr = 16'h0020; bus.imr = 16'hFFFF; bus.vr = 8'h40;
        step();
        tests++; if (bus.irq_n !== 1'b0) begin fails++; $display("FAIL basic_irq: got %b want 0", bus.irq_n); end
        bus.iack = 1'b1;
        step();
        tests++; if (bus.vec !== 8'h45) begin fails++; $display("FAIL basic_vec: got %h want 45", bus.vec); end
        tests++; if (bus.vec_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", bus.vec_valid); end
        tests++; if (bus.ipr_clr !== 16'h0020) begin fails++; $display("FAIL basic_clr: got %h want 0020", bus.ipr_clr); end
        tests++; if (bus.isr !== 16'h0000) begin fails++; $display("FAIL basic_isr: got %h want 0000", bus.isr); end
        bus.ipr = 16'h0000;
        step();
        tests++; if (bus.ipr_clr !== 16'h0000) begin fails++; $display("FAIL basic_clr_pulse: got %h want 0000", bus.ipr_clr); end
        tests++; if (bus.vec_valid !== 1'b1) begin fails++; $display("FAIL basic_valid_hold: got %b want 1", bus.vec_valid); end
        tests++; if (bus.irq_n !== 1'b1) begin fails++; $display("FAIL basic_irq_vec: got %b want 1", bus.irq_n); end
        bus.iack = 1'b0;
        step();
        tests++; if (bus.vec_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop: got %b want 0", bus.vec_valid); end
    endtask

    task automatic test_prio_mask();
        bus.ipr = 16'h8101; bus.imr = 16'h7FFF; bus.vr = 8'h48;
        step();
        tests++; if (bus.irq_n !== 1'b0) begin fails++; $display("FAIL prio_irq: got %b want 0", bus.irq_n); end
        bus.iack = 1'b1;
        step();
        tests++; if (bus.vec !== 8'h48) begin fails++; $display("FAIL prio_vec: got %h want 48", bus.vec); end
        tests++; if (bus.ipr_clr !== 16'h0100) begin fails++; $display("FAIL prio_clr: got %h want 0100", bus.ipr_clr); end
        tests++; if (bus.isr !== 16'h0100) begin fails++; $display("FAIL prio_isr: got %h want 0100", bus.isr); end
        // Pending register drops bit 8; raise channel 15 in IMR to show vec is frozen
        bus.ipr = 16'h8001; bus.imr = 16'hFFFF;
        step();
        tests++; if (bus.vec !== 8'h48) begin fails++; $display("FAIL prio_vec_frozen: got %h want 48", bus.vec); end
        bus.imr = 16'h7FFF;
        bus.iack = 1'b0;
        step();
        tests++; if (bus.vec_valid !== 1'b0) begin fails++; $display("FAIL prio_valid_drop: got %b want 0", bus.vec_valid); end
        step();
        tests++; if (bus.irq_n !== 1'b1) begin fails++; $display("FAIL prio_low_blocked: got %b want 1", bus.irq_n); end
    endtask

    task automatic test_nesting();
        bus.ipr = 16'h0010; bus.imr = 16'hFFFF; bus.vr = 8'h48;
        step(); step();
        tests++; if (bus.irq_n !== 1'b1) begin fails++; $display("FAIL nest_lower: got %b want 1", bus.irq_n); end
        bus.ipr = 16'h2010;
        step();
        tests++; if (bus.irq_n !== 1'b0) begin fails++; $display("FAIL nest_higher: got %b want 0", bus.irq_n); end
        bus.iack = 1'b1;
        step();
        tests++; if (bus.vec !== 8'h4D) begin fails++; $display("FAIL nest_vec: got %h want 4d", bus.vec); end
        tests++; if (bus.isr !== 16'h2100) begin fails++; $display("FAIL nest_isr: got %h want 2100", bus.isr); end
        bus.ipr = 16'h0010;
        step();
        bus.iack = 1'b0;
        step();
        bus.isr_wr = 1'b1; bus.isr_wdata = 16'hDFFF;
        step();
        bus.isr_wr = 1'b0;
        tests++; if (bus.isr !== 16'h0100) begin fails++; $display("FAIL nest_isr_wr: got %h want 0100", bus.isr); end
        step();
        tests++; if (bus.irq_n !== 1'b1) begin fails++; $display("FAIL nest_after_eoi: got %b want 1", bus.irq_n); end
    endtask

    task automatic test_back_to_back();
        // Clear ISR, then acknowledge channel 3 while the CPU writes all zeros
        bus.ipr = 16'h0000; bus.isr_wr = 1'b1; bus.isr_wdata = 16'h0000;
        step();
        bus.isr_wr = 1'b0;
        tests++; if (bus.isr !== 16'h0000) begin fails++; $display("FAIL simul_pre_isr: got %h want 0000", bus.isr); end
        bus.ipr = 16'h0008;
        step();
        bus.iack = 1'b1; bus.isr_wr = 1'b1; bus.isr_wdata = 16'h0000;
        step();
        bus.isr_wr = 1'b0; bus.ipr = 16'h0000;
        tests++; if (bus.isr !== 16'h0008) begin fails++; $display("FAIL simul_isr: got %h want 0008", bus.isr); end
        tests++; if (bus.vec !== 8'h43) begin fails++; $display("FAIL simul_vec: got %h want 43", bus.vec); end
        bus.iack = 1'b0;
        step();
        // Switching to automatic EOI empties the in-service register
        bus.vr = 8'h40;
        step();
        tests++; if (bus.isr !== 16'h0000) begin fails++; $display("FAIL auto_eoi: got %h want 0000", bus.isr); end
    endtask

    task automatic test_no_request();
        bus.ipr = 16'h0000; bus.vr = 8'h48;
        bus.iack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            tests++; if (bus.vec_valid !== 1'b0 || bus.ipr_clr !== 16'h0000) begin
                fails++; $display("FAIL noack_cycle%0d: got valid=%b clr=%h want 0/0000", i, bus.vec_valid, bus.ipr_clr);
            end
        end
        bus.iack = 1'b0;
        step();
        bus.ipr = 16'h0040;
        step();
        tests++; if (bus.irq_n !== 1'b0) begin fails++; $display("FAIL noack_recover_irq: got %b want 0", bus.irq_n); end
        bus.iack = 1'b1;
        step();
        tests++; if (bus.vec !== 8'h46 || bus.vec_valid !== 1'b1) begin
            fails++; $display("FAIL noack_recover_vec: got vec=%h valid=%b want 46/1", bus.vec, bus.vec_valid);
        end
        bus.ipr = 16'h0000;
        step();
        bus.iack = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bus.ipr = 16'h0080; bus.vr = 8'h48;
        step();
        bus.iack = 1'b1;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        tests++; if (bus.irq_n !== 1'b1) begin fails++; $display("FAIL rstmid_irq: got %b want 1", bus.irq_n); end
        tests++; if (bus.vec_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b want 0", bus.vec_valid); end
        tests++; if (bus.isr !== 16'h0000) begin fails++; $display("FAIL rstmid_isr: got %h want 0000", bus.isr); end
        tests++; if (bus.ipr_clr !== 16'h0000) begin fails++; $display("FAIL rstmid_clr: got %h want 0000", bus.ipr_clr); end
        step();
        bus.iack = 1'b0;
        reset_n  = 1'b1;
        step();
        tests++; if (bus.irq_n !== 1'b0) begin fails++; $display("FAIL rstmid_rerequest: got %b want 0", bus.irq_n); end
        bus.iack = 1'b1;
        step();
        tests++; if (bus.vec !== 8'h47 || bus.ipr_clr !== 16'h0080) begin
            fails++; $display("FAIL rstmid_reack: got vec=%h clr=%h want 47/0080", bus.vec, bus.ipr_clr);
        end
        bus.ipr = 16'h0000;
        step();
        bus.iack = 1'b0;
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_prio_mask();
        test_nesting();
        test_back_to_back();
        test_no_request();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mfp_irq_ctrl.md
Name: mfp_irq_ctrl

Overview:
- Interrupt prioritisation and acknowledge stage of the MFP. It sits directly downstream of the 16-bit pending-register flip-flop.
- It consumes the pending vector and the interrupt mask register (IMR), tracks in-service (ISR) bits, and drives the 68000 IRQ line.
- It answers IACK cycles with a vector and pulses a per-channel clear back into the pending register. Channel 15 has the highest priority; channel 0 the lowest.

Parameters:
- NCH, 16, number of interrupt channels. Only 16 is supported; it sets the vector field width.

Ports:
- clk  in  1  system clock (32 MHz)
- reset_n  in  1  asynchronous, active-low reset
- ipr  in  16  pending bits from the pending-register flip-flop
- imr  in  16  interrupt mask register; 1 = channel may request
- vr  in  8  vector register; [7:4] vector base, [3] S (software end-of-interrupt mode)
- isr_wr  in  1  one-cycle CPU write strobe to the ISR
- isr_wdata  in  16  ISR write data; bits written 0 clear, bits written 1 are unchanged
- iack  in  1  level; high for the duration of the CPU interrupt-acknowledge cycle
- irq_n  out  1  interrupt request to the CPU, active low, registered
- vec  out  8  vector number
- vec_valid  out  1  vec is valid; acts as DTACK for the IACK cycle
- ipr_clr  out  16  one-cycle pulse that clears the acknowledged pending bit
- isr  out  16  in-service register, readable by the CPU

Behaviour:
- Reset values (asynchronous): irq_n=1, vec=8'h00, vec_valid=0, ipr_clr=0, isr=0, iack_d=0, state=IDLE.
- Combinational terms:
  - act = ipr & imr.
  - hp_act = index of the highest set bit of act.
  - hp_isr = index of the highest set bit of isr.
  - req = (act!=0) && (isr==0 || hp_act > hp_isr).
- irq_n:
  - In IDLE, irq_n <= ~req (one-cycle latency).
  - In every other state irq_n <= 1.
- States:
  - IDLE: iack_d holds iack from the previous cycle. A rising edge is iack && !iack_d.
    - Rising edge with req=1: capture ch=hp_act and go to VEC. In the same clock: vec <= {vr[7:4], ch}, vec_valid <= 1, ipr_clr <= one-hot(ch). If vr[3]=1, set isr[ch].
    - Rising edge with req=0: go to NOACK. vec_valid stays 0.
  - VEC: ipr_clr <= 0 (the pulse is exactly one cycle). vec and vec_valid are held while iack=1. When iack=0: vec_valid <= 0, go to IDLE.
  - NOACK: wait for iack=0, then go to IDLE. No vector is driven and the CPU times out to a spurious interrupt.
- Latency: iack is sampled high at edge k; vec_valid and ipr_clr are visible after edge k.
- Channel selection: the channel is frozen at the iack edge. Later changes to ipr or imr do not alter vec during VEC.
- ISR update per cycle:
  - isr_next = ((isr_wr ? isr & isr_wdata : isr) | set_onehot).
  - When set and clear hit the same bit in one cycle, set wins.
- Automatic end-of-interrupt: when vr[3]=0, isr is forced to 0 on the next cycle, and isr bits are never set on acknowledge.
- irq_n re-evaluates in IDLE immediately after iack falls. This allows back-to-back nesting: a higher channel pending while a lower one is in service asserts irq_n.
- A new iack rising edge while in VEC or NOACK is impossible (iack is a level). A glitch-free low phase is required before the next acknowledge.
- Reset mid-acknowledge: all state clears asynchronously. Any ipr_clr pulse in flight is cut short; the pending bit may survive and is re-requested after reset.

Decomposition:
- Package mfp_pkg:
  - MFP_NCH=16 and VR_S_BIT=3.
  - State encoding enum {IDLE, VEC, NOACK}.
  - Function prio16(input [15:0]) returning {valid, idx[3:0]}.
- Sub-module mfp_prio16: a 16-to-4 highest-bit priority encoder with a valid output. It is instantiated twice, once for act and once for isr.

Test Plan:
- Reset: assert reset_n=0 mid-VEC -> irq_n=1, vec_valid=0, isr=0, ipr_clr=0 immediately. After release, state=IDLE.
- Basic acknowledge, S=0: ipr=16'h0020, imr=16'hFFFF, vr=8'h40 -> irq_n=0 one cycle later. Raise iack -> next cycle vec=8'h45, vec_valid=1, ipr_clr=16'h0020 for exactly one cycle, isr stays 0. Drop iack -> vec_valid=0.
- Priority and mask: ipr=16'h8101, imr=16'h7FFF, vr=8'h48 -> acknowledge gives vec=8'h48 (channel 8), ipr_clr=16'h0100, isr=16'h0100.
- Nesting, S=1: isr=16'h0100.
  - ipr=16'h0010 -> irq_n stays 1.
  - Then ipr=16'h2000 -> irq_n=0; acknowledge gives vec={vr[7:4],4'hD}, isr=16'h2100.
  - isr_wr with isr_wdata=16'hDFFF -> isr=16'h0100.
- Simultaneous ISR write and set: S=1, acknowledge of channel 3 in the same cycle as isr_wr with isr_wdata=16'h0000 -> isr=16'h0008.
- No request: ipr=0, raise iack for 10 cycles -> vec_valid stays 0, ipr_clr stays 0. After iack falls the block is in IDLE; a subsequent pending bit raises irq_n normally.
